// File: rtl/apx_float_adder_cfg.sv
// IEEE-754 single-precision add/subtract with configurable LSB approximation.
// Multi-cycle FSM, stb/ack handshake on each operand and on the result.
module apx_float_adder_cfg #(
   parameter int NAB       = 20,
   parameter int RND_MODE  = 0,
   parameter int MAX_SHIFT = 27
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   input  logic [31:0] input_b,
   input  logic        input_op,
   input  logic        apx_en,
   input  logic        input_b_stb,
   output logic        input_b_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   localparam logic [3:0] GET_A   = 4'd0;
   localparam logic [3:0] GET_B   = 4'd1;
   localparam logic [3:0] UNPACK  = 4'd2;
   localparam logic [3:0] SPECIAL = 4'd3;
   localparam logic [3:0] ALIGN   = 4'd4;
   localparam logic [3:0] ADD_0   = 4'd5;
   localparam logic [3:0] ADD_1   = 4'd6;
   localparam logic [3:0] NORM_1  = 4'd7;
   localparam logic [3:0] NORM_2  = 4'd8;
   localparam logic [3:0] ROUND   = 4'd9;
   localparam logic [3:0] PACK    = 4'd10;
   localparam logic [3:0] PUT_Z   = 4'd11;

   localparam logic signed [9:0] E_DEN  = -10'sd127;
   localparam logic signed [9:0] E_MIN  = -10'sd126;
   localparam logic signed [9:0] E_MAX  = 10'sd127;
   localparam logic signed [9:0] MAX_SH = 10'(MAX_SHIFT);
   localparam logic [22:0]       APX_MASK = 23'h7FFFFF << NAB;
   localparam logic [31:0]       QNAN     = 32'h7FC00000;

   logic [3:0]        state;
   logic [3:0]        state_nxt;
   logic              armed;
   logic [31:0]       a_raw;
   logic [31:0]       b_raw;
   logic              op_q;
   logic              apx_q;
   logic [26:0]       a_m;
   logic [26:0]       b_m;
   logic signed [9:0] a_e;
   logic signed [9:0] b_e;
   logic signed [9:0] z_e;
   logic              a_s;
   logic              b_s;
   logic              z_s;
   logic [27:0]       sum;
   logic [23:0]       z_m;
   logic              grd;
   logic              rnd;
   logic              stk;
   logic [31:0]       z;

   logic              a_xfer;
   logic              b_xfer;
   logic [22:0]       frac_mask;
   logic              a_nan;
   logic              b_nan;
   logic              a_inf;
   logic              b_inf;
   logic              a_zero;
   logic              b_zero;
   logic              spec_hit;
   logic [31:0]       spec_z;
   logic              a_big;
   logic signed [9:0] e_dif;
   logic              early;
   logic [26:0]       ext;
   logic              up_exact;
   logic              up_apx;
   logic              do_up;
   logic [24:0]       inc;
   logic [24:0]       z_m_inc;

   // Round-nearest-even with the kept LSB at bit p+3 of {mantissa, G, R, S}.
   function automatic logic round_up(input logic [26:0] v, input int p);
      logic [26:0] sh;
      logic [26:0] below;
      sh    = v >> (p + 2);
      below = v & ((27'd1 << (p + 2)) - 27'd1);
      return sh[0] & (sh[1] | (|below));
   endfunction

   assign a_xfer    = input_a_ack && input_a_stb;
   assign b_xfer    = input_b_ack && input_b_stb;
   assign frac_mask = apx_q ? APX_MASK : 23'h7FFFFF;

   // NaN/inf classification uses the raw fields so masking cannot hide a NaN payload.
   assign a_nan  = (&a_raw[30:23]) && (|a_raw[22:0]);
   assign b_nan  = (&b_raw[30:23]) && (|b_raw[22:0]);
   assign a_inf  = (&a_raw[30:23]) && !(|a_raw[22:0]);
   assign b_inf  = (&b_raw[30:23]) && !(|b_raw[22:0]);
   assign a_zero = (a_e == E_DEN) && (a_m == 27'd0);
   assign b_zero = (b_e == E_DEN) && (b_m == 27'd0);

   always_comb begin
      spec_hit = 1'b1;
      spec_z   = 32'd0;
      if (a_nan || b_nan) begin
         spec_z = QNAN;
      end else if (a_inf && b_inf && (a_s != b_s)) begin
         spec_z = QNAN;
      end else if (a_inf) begin
         spec_z = {a_s, 8'hFF, 23'd0};
      end else if (b_inf) begin
         spec_z = {b_s, 8'hFF, 23'd0};
      end else if (a_zero && b_zero) begin
         spec_z = {a_s & b_s, 31'd0};
      end else if (a_zero) begin
         spec_z = {b_s, b_raw[30:23], b_m[25:3]};
      end else if (b_zero) begin
         spec_z = {a_s, a_raw[30:23], a_m[25:3]};
      end else begin
         spec_hit = 1'b0;
      end
   end

   assign a_big = a_e > b_e;
   assign e_dif = a_big ? (a_e - b_e) : (b_e - a_e);
   assign early = e_dif >= MAX_SH;

   assign ext      = {z_m, grd, rnd, stk};
   assign up_exact = round_up(ext, 0);
   assign up_apx   = round_up(ext, NAB);
   assign do_up    = apx_q ? ((RND_MODE == 0) && up_apx) : up_exact;
   assign inc      = apx_q ? (25'd1 << NAB) : 25'd1;
   assign z_m_inc  = {1'b0, z_m} + inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= GET_A;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         GET_A:   if (a_xfer) state_nxt = GET_B;
         GET_B:   if (b_xfer) state_nxt = UNPACK;
         UNPACK:  state_nxt = SPECIAL;
         SPECIAL: state_nxt = spec_hit ? PUT_Z : ALIGN;
         ALIGN:   if ((a_e == b_e) || early) state_nxt = ADD_0;
         ADD_0:   state_nxt = ADD_1;
         ADD_1:   state_nxt = NORM_1;
         NORM_1:  if (z_m[23] || (z_e <= E_MIN)) state_nxt = NORM_2;
         NORM_2:  if (z_e >= E_MIN) state_nxt = ROUND;
         ROUND:   state_nxt = PACK;
         PACK:    state_nxt = PUT_Z;
         PUT_Z:   if (output_z_ack) state_nxt = GET_A;
         default: state_nxt = GET_A;
      endcase
   end

   always_comb begin
      input_a_ack  = (state == GET_A) && armed;
      input_b_ack  = (state == GET_B) && armed;
      output_z_stb = (state == PUT_Z);
      output_z     = z;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         armed <= 1'b0;
         z     <= 32'd0;
         a_raw <= 32'd0;
         b_raw <= 32'd0;
         op_q  <= 1'b0;
         apx_q <= 1'b0;
         a_m   <= 27'd0;
         b_m   <= 27'd0;
         a_e   <= 10'sd0;
         b_e   <= 10'sd0;
         z_e   <= 10'sd0;
         a_s   <= 1'b0;
         b_s   <= 1'b0;
         z_s   <= 1'b0;
         sum   <= 28'd0;
         z_m   <= 24'd0;
         grd   <= 1'b0;
         rnd   <= 1'b0;
         stk   <= 1'b0;
      end else begin
         // ack goes high only after a full cycle in the operand state
         armed <= ((state == GET_A) && !a_xfer) || ((state == GET_B) && !b_xfer);
         case (state)
            GET_A: begin
               if (a_xfer) a_raw <= input_a;
            end
            GET_B: begin
               if (b_xfer) begin
                  b_raw <= input_b;
                  op_q  <= input_op;
                  apx_q <= apx_en;
               end
            end
            UNPACK: begin
               a_m <= {1'b0, a_raw[22:0] & frac_mask, 3'd0};
               b_m <= {1'b0, b_raw[22:0] & frac_mask, 3'd0};
               a_e <= $signed({2'b00, a_raw[30:23]}) - 10'sd127;
               b_e <= $signed({2'b00, b_raw[30:23]}) - 10'sd127;
               a_s <= a_raw[31];
               b_s <= b_raw[31] ^ op_q;
            end
            SPECIAL: begin
               if (spec_hit) begin
                  z <= spec_z;
               end else begin
                  if (a_e == E_DEN) a_e <= E_MIN;
                  else              a_m[26] <= 1'b1;
                  if (b_e == E_DEN) b_e <= E_MIN;
                  else              b_m[26] <= 1'b1;
               end
            end
            ALIGN: begin
               if (a_e != b_e) begin
                  if (a_big) begin
                     if (early) begin
                        b_e <= a_e;
                        b_m <= {26'd0, |b_m};
                     end else begin
                        b_e <= b_e + 10'sd1;
                        b_m <= {1'b0, b_m[26:2], b_m[1] | b_m[0]};
                     end
                  end else begin
                     if (early) begin
                        a_e <= b_e;
                        a_m <= {26'd0, |a_m};
                     end else begin
                        a_e <= a_e + 10'sd1;
                        a_m <= {1'b0, a_m[26:2], a_m[1] | a_m[0]};
                     end
                  end
               end
            end
            ADD_0: begin
               z_e <= a_e;
               if (a_s == b_s) begin
                  sum <= {1'b0, a_m} + {1'b0, b_m};
                  z_s <= a_s;
               end else if (a_m > b_m) begin
                  sum <= {1'b0, a_m} - {1'b0, b_m};
                  z_s <= a_s;
               end else if (a_m < b_m) begin
                  sum <= {1'b0, b_m} - {1'b0, a_m};
                  z_s <= b_s;
               end else begin
                  sum <= 28'd0;
                  z_s <= 1'b0;
               end
            end
            ADD_1: begin
               if (sum[27]) begin
                  z_m <= sum[27:4];
                  grd <= sum[3];
                  rnd <= sum[2];
                  stk <= sum[1] | sum[0];
                  z_e <= z_e + 10'sd1;
               end else begin
                  z_m <= sum[26:3];
                  grd <= sum[2];
                  rnd <= sum[1];
                  stk <= sum[0];
               end
            end
            NORM_1: begin
               if (!z_m[23] && (z_e > E_MIN)) begin
                  z_e <= z_e - 10'sd1;
                  z_m <= {z_m[22:0], grd};
                  grd <= rnd;
                  rnd <= 1'b0;
               end
            end
            NORM_2: begin
               if (z_e < E_MIN) begin
                  z_e <= z_e + 10'sd1;
                  z_m <= {1'b0, z_m[23:1]};
                  grd <= z_m[0];
                  rnd <= grd;
                  stk <= stk | rnd;
               end
            end
            ROUND: begin
               if (do_up) begin
                  if (z_m_inc[24]) begin
                     z_m <= 24'h800000;
                     z_e <= z_e + 10'sd1;
                  end else begin
                     z_m <= z_m_inc[23:0];
                  end
               end
            end
            PACK: begin
               if (z_e > E_MAX) begin
                  z <= {z_s, 8'hFF, 23'd0};
               end else if ((z_e == E_MIN) && !z_m[23]) begin
                  z <= {z_s, 8'd0, z_m[22:0] & frac_mask};
               end else begin
                  z <= {z_s, z_e[7:0] + 8'd127, z_m[22:0] & frac_mask};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apx_float_adder_cfg.sv
// Directed bench for apx_float_adder_cfg (NAB=20, RND_MODE=0, MAX_SHIFT=27).
module tb_apx_float_adder_cfg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] input_a = 32'd0;
   logic        input_a_stb = 1'b0;
   logic        input_a_ack;
   logic [31:0] input_b = 32'd0;
   logic        input_op = 1'b0;
   logic        apx_en = 1'b0;
   logic        input_b_stb = 1'b0;
   logic        input_b_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack = 1'b0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic        apx;
      logic [31:0] z;
      int          lat;
   } vec_t;

   always #5 clk = ~clk;

   apx_float_adder_cfg #(.NAB(20), .RND_MODE(0), .MAX_SHIFT(27)) dut (
      .clk(clk), .rst(rst),
      .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
      .input_b(input_b), .input_op(input_op), .apx_en(apx_en),
      .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
      .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Latency counts the B-transfer cycle itself through to the first stb sample.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                           input logic apx, input bit wait_z,
                           output int lat, output int a_hi, output int b_hi);
      bit done;
      lat = -1; a_hi = 0; b_hi = 0;
      input_a = a; input_a_stb = 1'b1; done = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         done = input_a_ack;
         a_hi += int'(input_a_ack);
         tick();
      end
      a_hi += int'(input_a_ack);
      input_a_stb = 1'b0;
      checks++;
      if (!done) begin errors++; $display("FAIL a_transfer: no ack in 20 cycles, required a transfer"); end
      input_b = b; input_op = op; apx_en = apx; input_b_stb = 1'b1; done = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         done = input_b_ack;
         b_hi += int'(input_b_ack);
         tick();
      end
      b_hi += int'(input_b_ack);
      input_b_stb = 1'b0;
      checks++;
      if (!done) begin errors++; $display("FAIL b_transfer: no ack in 20 cycles, required a transfer"); end
      if (wait_z) begin
         lat = 1;
         while (!output_z_stb && lat < 400) begin
            tick();
            lat++;
         end
         checks++;
         if (!output_z_stb) begin errors++; $display("FAIL z_timeout: stb=0 after 400 cycles, required stb=1"); end
      end
   endtask

   task automatic finish_op();
      output_z_ack = 1'b1;
      tick();
      output_z_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({input_a_ack, input_b_ack, output_z_stb} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl: got %b, required 000", {input_a_ack, input_b_ack, output_z_stb});
      end
      checks++;
      if (output_z !== 32'd0) begin errors++; $display("FAIL reset_z: got %h, required 00000000", output_z); end
      rst = 1'b0;
      tick();
      checks++;
      if (input_a_ack !== 1'b1) begin errors++; $display("FAIL reset_ack_rise: got %b, required 1", input_a_ack); end
   endtask

   task automatic test_handshake();
      int lat, ah, bh;
      start_op(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b1, lat, ah, bh);
      checks++;
      if (output_z !== 32'h40000000) begin errors++; $display("FAIL hs_z: got %h, required 40000000", output_z); end
      checks++;
      if (ah != 1) begin errors++; $display("FAIL hs_a_ack_pulse: got %0d high cycles, required 1", ah); end
      checks++;
      if (bh != 1) begin errors++; $display("FAIL hs_b_ack_pulse: got %0d high cycles, required 1", bh); end
      checks++;
      if (lat != 10) begin errors++; $display("FAIL hs_latency: got %0d, required 10", lat); end
      finish_op();
      checks++;
      if (output_z_stb !== 1'b0) begin errors++; $display("FAIL hs_stb_pulse: got %b, required 0", output_z_stb); end
   endtask

   task automatic test_exact();
      vec_t v [9];
      int lat, ah, bh;
      v = '{'{32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h40000000, 10},
            '{32'h3F800000, 32'h34000000, 1'b0, 1'b0, 32'h3F800001, 33},
            '{32'h3F800000, 32'h33800000, 1'b0, 1'b0, 32'h3F800000, 34},
            '{32'h3F800001, 32'h33800000, 1'b0, 1'b0, 32'h3F800002, 34},
            '{32'h3F800003, 32'h3F800000, 1'b0, 1'b0, 32'h40000002, 10},
            '{32'h3F800000, 32'h3D800000, 1'b0, 1'b0, 32'h3F880000, 14},
            '{32'h3F800000, 32'h3DC00000, 1'b0, 1'b0, 32'h3F8C0000, 14},
            '{32'h3F880000, 32'h3F800000, 1'b0, 1'b0, 32'h40040000, 10},
            '{32'h3FF00000, 32'h3DC00000, 1'b0, 1'b0, 32'h3FFC0000, 14}};
      foreach (v[i]) begin
         start_op(v[i].a, v[i].b, v[i].op, v[i].apx, 1'b1, lat, ah, bh);
         checks++;
         if (output_z !== v[i].z) begin errors++; $display("FAIL exact[%0d]_z: got %h, required %h", i, output_z, v[i].z); end
         checks++;
         if (lat != v[i].lat) begin errors++; $display("FAIL exact[%0d]_lat: got %0d, required %0d", i, lat, v[i].lat); end
         finish_op();
      end
   endtask

   task automatic test_approx();
      vec_t v [6];
      int lat, ah, bh;
      v = '{'{32'h3F800000, 32'h34000000, 1'b0, 1'b1, 32'h3F800000, 33},
            '{32'h3F800003, 32'h3F800000, 1'b0, 1'b1, 32'h40000000, 10},
            '{32'h3F800000, 32'h3D800000, 1'b0, 1'b1, 32'h3F800000, 14},
            '{32'h3F800000, 32'h3DC00000, 1'b0, 1'b1, 32'h3F900000, 14},
            '{32'h3F880000, 32'h3F800000, 1'b0, 1'b1, 32'h40000000, 10},
            '{32'h3FF00000, 32'h3DC00000, 1'b0, 1'b1, 32'h40000000, 14}};
      foreach (v[i]) begin
         start_op(v[i].a, v[i].b, v[i].op, v[i].apx, 1'b1, lat, ah, bh);
         checks++;
         if (output_z !== v[i].z) begin errors++; $display("FAIL approx[%0d]_z: got %h, required %h", i, output_z, v[i].z); end
         checks++;
         if (lat != v[i].lat) begin errors++; $display("FAIL approx[%0d]_lat: got %0d, required %0d", i, lat, v[i].lat); end
         finish_op();
      end
   endtask

   task automatic test_subtract();
      vec_t v [6];
      int lat, ah, bh;
      v = '{'{32'h40400000, 32'h3F800000, 1'b1, 1'b0, 32'h40000000, 11},
            '{32'h3F800000, 32'h40400000, 1'b1, 1'b0, 32'hC0000000, 11},
            '{32'h3FC00000, 32'h3FA00000, 1'b1, 1'b0, 32'h3E800000, 12},
            '{32'h00800000, 32'h00400000, 1'b1, 1'b0, 32'h00400000, 10},
            '{32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 32'h00000000, 136},
            '{32'h3F800000, 32'hBF800000, 1'b0, 1'b0, 32'h00000000, 136}};
      foreach (v[i]) begin
         start_op(v[i].a, v[i].b, v[i].op, v[i].apx, 1'b1, lat, ah, bh);
         checks++;
         if (output_z !== v[i].z) begin errors++; $display("FAIL sub[%0d]_z: got %h, required %h", i, output_z, v[i].z); end
         checks++;
         if (lat != v[i].lat) begin errors++; $display("FAIL sub[%0d]_lat: got %0d, required %0d", i, lat, v[i].lat); end
         finish_op();
      end
   endtask

   task automatic test_special();
      vec_t v [12];
      int lat, ah, bh;
      v = '{'{32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 32'h7FC00000, 3},
            '{32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 3},
            '{32'h3F800000, 32'h7F800001, 1'b0, 1'b1, 32'h7FC00000, 3},
            '{32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 32'h7F800000, 3},
            '{32'h3F800000, 32'h7F800000, 1'b1, 1'b0, 32'hFF800000, 3},
            '{32'h7F800000, 32'h7F800000, 1'b0, 1'b0, 32'h7F800000, 3},
            '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 3},
            '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 3},
            '{32'h00000000, 32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 3},
            '{32'h3F800000, 32'h00000000, 1'b1, 1'b0, 32'h3F800000, 3},
            '{32'h00000000, 32'h3F800003, 1'b1, 1'b1, 32'hBF800000, 3},
            '{32'h00000005, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 3}};
      foreach (v[i]) begin
         start_op(v[i].a, v[i].b, v[i].op, v[i].apx, 1'b1, lat, ah, bh);
         checks++;
         if (output_z !== v[i].z) begin errors++; $display("FAIL special[%0d]_z: got %h, required %h", i, output_z, v[i].z); end
         checks++;
         if (lat != v[i].lat) begin errors++; $display("FAIL special[%0d]_lat: got %0d, required %0d", i, lat, v[i].lat); end
         finish_op();
      end
   endtask

   task automatic test_shift_limit();
      vec_t v [5];
      int lat, ah, bh;
      v = '{'{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F800000, 10},
            '{32'h4B000000, 32'h00000001, 1'b0, 1'b0, 32'h4B000000, 10},
            '{32'h00000001, 32'h4B000000, 1'b0, 1'b0, 32'h4B000000, 10},
            '{32'h3F800000, 32'h32800000, 1'b0, 1'b0, 32'h3F800000, 36},
            '{32'h3F800000, 32'h32000000, 1'b0, 1'b0, 32'h3F800000, 10}};
      foreach (v[i]) begin
         start_op(v[i].a, v[i].b, v[i].op, v[i].apx, 1'b1, lat, ah, bh);
         checks++;
         if (output_z !== v[i].z) begin errors++; $display("FAIL shift[%0d]_z: got %h, required %h", i, output_z, v[i].z); end
         checks++;
         if (lat != v[i].lat) begin errors++; $display("FAIL shift[%0d]_lat: got %0d, required %0d", i, lat, v[i].lat); end
         finish_op();
      end
   endtask

   task automatic test_hold();
      int lat, ah, bh;
      start_op(32'h40400000, 32'h3F800000, 1'b0, 1'b0, 1'b1, lat, ah, bh);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (output_z_stb !== 1'b1) begin errors++; $display("FAIL hold_stb[%0d]: got %b, required 1", k, output_z_stb); end
         checks++;
         if (output_z !== 32'h40800000) begin errors++; $display("FAIL hold_z[%0d]: got %h, required 40800000", k, output_z); end
         tick();
      end
      finish_op();
      checks++;
      if (output_z_stb !== 1'b0) begin errors++; $display("FAIL hold_release: got %b, required 0", output_z_stb); end
   endtask

   task automatic test_reset_in_align();
      int lat, ah, bh, seen;
      start_op(32'h3F800000, 32'h34000000, 1'b0, 1'b0, 1'b0, lat, ah, bh);
      tick(); tick();
      checks++;
      if (dut.state !== 4'd4) begin errors++; $display("FAIL mid_state: got %0d, required 4 (ALIGN)", dut.state); end
      rst = 1'b1;
      tick();
      checks++;
      if ({input_a_ack, input_b_ack, output_z_stb} !== 3'b000) begin
         errors++; $display("FAIL mid_reset_ctrl: got %b, required 000", {input_a_ack, input_b_ack, output_z_stb});
      end
      checks++;
      if (output_z !== 32'd0) begin errors++; $display("FAIL mid_reset_z: got %h, required 00000000", output_z); end
      checks++;
      if (dut.state !== 4'd0) begin errors++; $display("FAIL mid_reset_state: got %0d, required 0 (GET_A)", dut.state); end
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         seen += int'(output_z_stb);
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL mid_reset_discard: got %0d stb cycles, required 0", seen); end
      start_op(32'h40400000, 32'h3F800000, 1'b1, 1'b0, 1'b1, lat, ah, bh);
      checks++;
      if (output_z !== 32'h40000000) begin errors++; $display("FAIL post_reset_z: got %h, required 40000000", output_z); end
      finish_op();
   endtask

   initial begin
      test_reset();
      test_handshake();
      test_exact();
      test_approx();
      test_subtract();
      test_special();
      test_shift_limit();
      test_hold();
      test_reset_in_align();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule

// File: doc/apx_float_adder_cfg.md
Name: apx_float_adder_cfg

Overview:
- Single-precision IEEE-754 add/subtract unit with compile-time approximation width and per-operation runtime exact/approximate selection.
- Successor to the fixed-width approximate adder. Adds subtract, configurable rounding, early-out alignment, inf-inf NaN handling, and a canonical NaN.
- Sits in the float_ops_apx library.
- Uses the same stb/ack operand/result handshake as the other float operators, so it is a drop-in replacement.

Parameters:
- NAB, 20: number of mantissa fraction LSBs approximated when apx_en=1. Legal range 0..22; 0 makes approximate mode equal exact mode.
- RND_MODE, 0: rounding used in approximate mode. 0 = round-nearest-even at bit position NAB; 1 = truncate. Exact mode always uses round-nearest-even at bit 0.
- MAX_SHIFT, 27: alignment shift limit. An exponent difference ≥ MAX_SHIFT collapses the smaller operand to its sticky bit in one cycle.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- input_a  in  32  operand A
- input_a_stb  in  1  A valid
- input_a_ack  out  1  A accepted
- input_b  in  32  operand B
- input_op  in  1  sampled with B; 0 = A+B, 1 = A−B
- apx_en  in  1  sampled with B; 1 = approximate mode
- input_b_stb  in  1  B valid
- input_b_ack  out  1  B accepted
- output_z  out  32  result
- output_z_stb  out  1  result valid
- output_z_ack  in  1  result consumed

Behaviour:
- Reset (clk edge with rst=1, wins over any state, including mid-operation):
  - state=GET_A; input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0.
  - Any in-flight operation is discarded, with no output.
- FSM: GET_A → GET_B → UNPACK → SPECIAL → ALIGN → ADD_0 → ADD_1 → NORM_1 → NORM_2 → ROUND → PACK → PUT_Z → GET_A.
- GET_A / GET_B:
  - ack rises the cycle after entry.
  - Transfer happens on a cycle with ack && stb; ack drops the next cycle.
  - input_op and apx_en are captured on the B transfer.
  - Minimum of 2 cycles per operand.
- UNPACK:
  - b sign is XORed with op.
  - Exponents are unbiased into 10-bit signed values.
  - Mantissa is 27 bits: hidden, 23 fraction, guard, round, sticky.
  - If apx_en, fraction bits [NAB-1:0] of both operands are forced to 0.
- SPECIAL (result goes straight to PUT_Z):
  - Either operand NaN → 0x7FC00000.
  - inf + (−inf) after op applied → 0x7FC00000.
  - Either operand inf → that inf with its (effective) sign.
  - Both zero → zero with sign a_s & b_s.
  - One operand zero → the other (effective sign, masked fraction if apx_en).
  - Otherwise: a denormal exponent of −127 becomes −126; a normal sets the hidden bit.
- ALIGN:
  - Shift the smaller-exponent mantissa right by 1 per cycle, ORing bit 1 into the sticky bit.
  - If the exponent difference ≥ MAX_SHIFT, finish in one cycle: mantissa becomes sticky-only (bit0 = OR of mantissa), exponent is equalised.
- ADD_0:
  - Equal signs: add.
  - Different signs: subtract the smaller from the larger; the sign comes from the larger.
  - Equal magnitudes with opposite sign give +0.
  - The sum is 28 bits.
- ADD_1: on carry-out, take the upper 24 bits and increment the exponent; guard, round and sticky are formed accordingly.
- NORM_1: while the hidden bit is 0 and exp > −126, shift left 1 and decrement the exponent.
- NORM_2: while exp < −126, shift right 1 and increment the exponent, accumulating sticky.
- ROUND:
  - Exact mode, or approximate with RND_MODE=0: round-nearest-even at position p, where p=0 (exact) or p=NAB (approximate). The guard is the bit below p (for p>0 that is bit p−1 of the fraction, with lower bits plus G/R/S as sticky).
  - Mantissa overflow from rounding increments the exponent and sets the mantissa to 1.0.
  - Approximate with RND_MODE=1: no increment.
- PACK:
  - In approximate mode, fraction bits [NAB-1:0] are forced to 0.
  - exp = −126 with hidden bit 0 packs a biased exponent of 0 (denormal).
  - exp > 127 packs inf with the result sign.
- PUT_Z:
  - output_z is loaded and output_z_stb=1 held until a cycle with stb && output_z_ack.
  - stb then drops, and the FSM returns to GET_A.
  - output_z is held stable while stb=1.
- Latency: variable; from B transfer to stb, 10 cycles plus the alignment and normalise iteration counts. Special cases take 3 cycles.

Test Plan:
- 0x3F800000 + 0x3F800000, apx_en=0 → 0x40000000. Check the ack/stb single-cycle pulses.
- 0x3F800000 + 0x34000000, apx_en=0 → 0x3F800001. Same inputs with apx_en=1, NAB=20 → 0x3F800000 (low 20 fraction bits zero).
- op=1: 0x40400000 − 0x3F800000 → 0x40000000. 0x3F800000 − 0x3F800000 → 0x00000000.
- 0x7F800000 − 0x7F800000 → 0x7FC00000. 0x7FC00000 + 0x3F800000 → 0x7FC00000. 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
- 0x4B000000 + 0x00000001 (exponent gap ≥ MAX_SHIFT) → 0x4B000000. Check that the ALIGN residency is 1 cycle.
- Hold output_z_ack=0 for 5 cycles → output_z and stb stable throughout. Assert rst during ALIGN → next cycle all outputs 0 and the FSM is in GET_A.
